// File: rtl/frame_write_sequencer_if.sv
// rtl/frame_write_sequencer_if.sv - write port bundle between the frame write sequencer and the frame manager
interface frame_write_sequencer_if #(
  parameter int COLOR_DEPTH       = 9,
  parameter int DRAW_WIDTH_ADDRW  = 10,
  parameter int DRAW_HEIGHT_ADDRW = 9,
  parameter int SOURCE_SEL_ADDRW  = 4
);
  logic                         wr_active;
  logic                         wr_transparent;
  logic [COLOR_DEPTH-1:0]       wr_color;
  logic [DRAW_WIDTH_ADDRW-1:0]  wr_x;
  logic [DRAW_HEIGHT_ADDRW-1:0] wr_y;
  logic [SOURCE_SEL_ADDRW-1:0]  wr_source_sel;

  modport master (
    output wr_active, wr_transparent, wr_color, wr_x, wr_y, wr_source_sel
  );

  modport slave (
    input wr_active, wr_transparent, wr_color, wr_x, wr_y, wr_source_sel
  );
endinterface

// File: rtl/frame_write_sequencer.sv
// rtl/frame_write_sequencer.sv - per-frame painter's-order arbiter of N drawing sources onto one write port
module frame_write_sequencer #(
  parameter int NUM_SOURCES       = 4,
  parameter int SOURCE_SEL_ADDRW  = 4,
  parameter int COLOR_DEPTH       = 9,
  parameter int DRAW_WIDTH_ADDRW  = 10,
  parameter int DRAW_HEIGHT_ADDRW = 9,
  parameter int TIMEOUT_CYCLES    = 0,
  parameter int OVERRUN_RESTART   = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   frame,
  input  logic [NUM_SOURCES-1:0]                 src_enable,
  input  logic [NUM_SOURCES-1:0]                 src_active,
  input  logic [NUM_SOURCES-1:0]                 src_done,
  input  logic [NUM_SOURCES*COLOR_DEPTH-1:0]     src_color,
  input  logic [NUM_SOURCES-1:0]                 src_transparent,
  input  logic [NUM_SOURCES*DRAW_WIDTH_ADDRW-1:0]  src_x,
  input  logic [NUM_SOURCES*DRAW_HEIGHT_ADDRW-1:0] src_y,
  output logic [NUM_SOURCES-1:0]                 src_awaited,
  frame_write_sequencer_if.master                wr,
  output logic                                   pass_busy,
  output logic [7:0]                             overrun_count,
  output logic                                   timeout_flag,
  output logic [SOURCE_SEL_ADDRW-1:0]            timeout_src
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SOURCE_SEL_ADDRW-1:0] LAST_IDX = SOURCE_SEL_ADDRW'(NUM_SOURCES - 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {WAIT, SCAN, GRANT} state_t;

  state_t                        state, state_n;
  logic [SOURCE_SEL_ADDRW-1:0]   idx, idx_n, sel_q;
  logic [WD_W-1:0]               wd_cnt, wd_n;
  logic                          expire, overrun, granted;

  logic                          en_sel, act_sel, done_sel, tr_sel;
  logic [COLOR_DEPTH-1:0]        color_sel;
  logic [DRAW_WIDTH_ADDRW-1:0]   x_sel;
  logic [DRAW_HEIGHT_ADDRW-1:0]  y_sel;

  always_comb begin
    en_sel    = 1'b0;
    act_sel   = 1'b0;
    done_sel  = 1'b0;
    tr_sel    = 1'b0;
    color_sel = '0;
    x_sel     = '0;
    y_sel     = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (idx == SOURCE_SEL_ADDRW'(i)) begin
        en_sel    = src_enable[i];
        act_sel   = src_active[i];
        done_sel  = src_done[i];
        tr_sel    = src_transparent[i];
        color_sel = src_color[i*COLOR_DEPTH +: COLOR_DEPTH];
        x_sel     = src_x[i*DRAW_WIDTH_ADDRW +: DRAW_WIDTH_ADDRW];
        y_sel     = src_y[i*DRAW_HEIGHT_ADDRW +: DRAW_HEIGHT_ADDRW];
      end
    end
  end

  assign overrun = frame && (state != WAIT);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    wd_n    = wd_cnt;
    expire  = 1'b0;
    case (state)
      WAIT: begin
        if (frame) begin
          state_n = SCAN;
          idx_n   = '0;
        end
      end
      SCAN: begin
        if (en_sel) begin
          state_n = GRANT;
          wd_n    = '0;
        end else if (idx == LAST_IDX) begin
          state_n = WAIT;
        end else begin
          idx_n = idx + SOURCE_SEL_ADDRW'(1);
        end
      end
      GRANT: begin
        wd_n   = wd_cnt + WD_W'(1);
        // a done on the expiry cycle is a normal completion, not a timeout
        expire = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LIMIT) && !done_sel;
        if (done_sel || expire) begin
          if (idx == LAST_IDX) begin
            state_n = WAIT;
          end else begin
            state_n = SCAN;
            idx_n   = idx + SOURCE_SEL_ADDRW'(1);
          end
        end
      end
      default: begin
        state_n = WAIT;
        idx_n   = '0;
      end
    endcase
    // restart outranks any advance decided above
    if (overrun && (OVERRUN_RESTART != 0)) begin
      state_n = SCAN;
      idx_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= WAIT;
      idx           <= '0;
      wd_cnt        <= '0;
      src_awaited   <= '0;
      sel_q         <= '0;
      overrun_count <= 8'd0;
      timeout_flag  <= 1'b0;
      timeout_src   <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      wd_cnt      <= wd_n;
      src_awaited <= (state_n == GRANT) ? (NUM_SOURCES'(1) << idx_n) : '0;
      sel_q       <= (state_n == GRANT) ? idx_n : '0;
      if (overrun && (overrun_count != 8'hff)) begin
        overrun_count <= overrun_count + 8'd1;
      end
      if (expire) begin
        timeout_flag <= 1'b1;
        timeout_src  <= idx;
      end
    end
  end

  assign granted   = (state == GRANT);
  assign pass_busy = (state != WAIT);

  // the bus is zeroed outside GRANT so the frame manager never sees a stale source
  assign wr.wr_active      = granted & act_sel;
  assign wr.wr_transparent = granted & tr_sel;
  assign wr.wr_color       = granted ? color_sel : '0;
  assign wr.wr_x           = granted ? x_sel : '0;
  assign wr.wr_y           = granted ? y_sel : '0;
  assign wr.wr_source_sel  = sel_q;

endmodule

// File: tb/tb_frame_write_sequencer.sv
// tb/tb_frame_write_sequencer.sv - directed self-checking bench for frame_write_sequencer
module tb_frame_write_sequencer;
  localparam int NS = 4;
  localparam int CD = 9;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int SW = 4;
  localparam int BW = 1 + CD + XW + YW;

  logic clk = 1'b0;
  logic reset, frame;
  logic [NS-1:0]    src_enable, src_active, src_done, src_transparent;
  logic [NS*CD-1:0] src_color;
  logic [NS*XW-1:0] src_x;
  logic [NS*YW-1:0] src_y;

  logic [NS-1:0] aw_r, aw_n;
  logic          busy_r, busy_n, tflag_r, tflag_n;
  logic [7:0]    ovr_r, ovr_n;
  logic [SW-1:0] tsrc_r, tsrc_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_write_sequencer_if #(.COLOR_DEPTH(CD), .DRAW_WIDTH_ADDRW(XW), .DRAW_HEIGHT_ADDRW(YW), .SOURCE_SEL_ADDRW(SW)) wr_r ();
  frame_write_sequencer_if #(.COLOR_DEPTH(CD), .DRAW_WIDTH_ADDRW(XW), .DRAW_HEIGHT_ADDRW(YW), .SOURCE_SEL_ADDRW(SW)) wr_n ();

  frame_write_sequencer #(
    .NUM_SOURCES(NS), .SOURCE_SEL_ADDRW(SW), .COLOR_DEPTH(CD), .DRAW_WIDTH_ADDRW(XW),
    .DRAW_HEIGHT_ADDRW(YW), .TIMEOUT_CYCLES(8), .OVERRUN_RESTART(1)
  ) dut_r (
    .clk(clk), .reset(reset), .frame(frame), .src_enable(src_enable), .src_active(src_active),
    .src_done(src_done), .src_color(src_color), .src_transparent(src_transparent),
    .src_x(src_x), .src_y(src_y), .src_awaited(aw_r), .wr(wr_r), .pass_busy(busy_r),
    .overrun_count(ovr_r), .timeout_flag(tflag_r), .timeout_src(tsrc_r)
  );

  frame_write_sequencer #(
    .NUM_SOURCES(NS), .SOURCE_SEL_ADDRW(SW), .COLOR_DEPTH(CD), .DRAW_WIDTH_ADDRW(XW),
    .DRAW_HEIGHT_ADDRW(YW), .TIMEOUT_CYCLES(8), .OVERRUN_RESTART(0)
  ) dut_n (
    .clk(clk), .reset(reset), .frame(frame), .src_enable(src_enable), .src_active(src_active),
    .src_done(src_done), .src_color(src_color), .src_transparent(src_transparent),
    .src_x(src_x), .src_y(src_y), .src_awaited(aw_n), .wr(wr_n), .pass_busy(busy_n),
    .overrun_count(ovr_n), .timeout_flag(tflag_n), .timeout_src(tsrc_n)
  );

  function automatic logic [CD-1:0] col_of(input int i); return CD'(16 * i + 3); endfunction
  function automatic logic [XW-1:0] x_of(input int i); return XW'(100 + 7 * i); endfunction
  function automatic logic [YW-1:0] y_of(input int i); return YW'(40 + 5 * i); endfunction
  function automatic logic tr_of(input int i); return (i % 2) == 1; endfunction
  function automatic logic [BW-1:0] bus_of(input int i); return {tr_of(i), col_of(i), x_of(i), y_of(i)}; endfunction

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic pulse_frame(); frame = 1'b1; tick(); frame = 1'b0; endtask
  task automatic pulse_done(input int i); src_done = NS'(1 << i); tick(); src_done = '0; endtask
  task automatic do_reset();
    frame = 1'b0; src_done = '0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    src_enable = '1; src_active = '1;
    do_reset();
    checks++; if (aw_r !== 4'b0000) begin errors++; $display("FAIL reset_awaited: got %b want 0000", aw_r); end
    checks++; if ({wr_r.wr_active, wr_r.wr_transparent, wr_r.wr_color, wr_r.wr_x, wr_r.wr_y} !== '0) begin
      errors++; $display("FAIL reset_bus: got %h want 0", {wr_r.wr_active, wr_r.wr_transparent, wr_r.wr_color, wr_r.wr_x, wr_r.wr_y}); end
    checks++; if ({wr_r.wr_source_sel, busy_r, ovr_r, tflag_r, tsrc_r} !== '0) begin
      errors++; $display("FAIL reset_status: got %h want 0", {wr_r.wr_source_sel, busy_r, ovr_r, tflag_r, tsrc_r}); end
  endtask

  task automatic test_painter_order();
    src_enable = '1; src_active = '1;
    repeat (3) tick();
    pulse_frame();
    checks++; if ({busy_r, aw_r} !== 5'b1_0000) begin errors++; $display("FAIL order_scan: got %b want 10000", {busy_r, aw_r}); end
    tick();
    for (int i = 0; i < NS; i++) begin
      checks++; if (aw_r !== NS'(1 << i)) begin errors++; $display("FAIL order_grant%0d: got %b want %b", i, aw_r, NS'(1 << i)); end
      checks++; if (wr_r.wr_source_sel !== SW'(i)) begin errors++; $display("FAIL order_sel%0d: got %0d want %0d", i, wr_r.wr_source_sel, i); end
      checks++; if ({wr_r.wr_transparent, wr_r.wr_color, wr_r.wr_x, wr_r.wr_y} !== bus_of(i) || wr_r.wr_active !== 1'b1) begin
        errors++; $display("FAIL order_bus%0d: got %h/%b want %h/1", i, {wr_r.wr_transparent, wr_r.wr_color, wr_r.wr_x, wr_r.wr_y}, wr_r.wr_active, bus_of(i)); end
      repeat (5) tick();
      checks++; if (aw_r !== NS'(1 << i)) begin errors++; $display("FAIL order_hold%0d: got %b want %b", i, aw_r, NS'(1 << i)); end
      pulse_done(i);
      checks++; if ({busy_r, aw_r, wr_r.wr_active} !== {(i < NS - 1), 4'b0000, 1'b0}) begin
        errors++; $display("FAIL order_after_done%0d: got %b want %b", i, {busy_r, aw_r, wr_r.wr_active}, {(i < NS - 1), 5'b0}); end
      if (i < NS - 1) tick();
    end
  endtask

  task automatic test_enable_mask();
    do_reset();
    src_enable = 4'b0101; src_active = '1;
    pulse_frame();
    tick();
    checks++; if (aw_r !== 4'b0001) begin errors++; $display("FAIL mask_grant0: got %b want 0001", aw_r); end
    pulse_done(0);
    tick();
    checks++; if ({aw_r, wr_r.wr_active, busy_r} !== 6'b0000_0_1) begin
      errors++; $display("FAIL mask_skip1: got %b want 000001", {aw_r, wr_r.wr_active, busy_r}); end
    tick();
    checks++; if (aw_r !== 4'b0100 || wr_r.wr_x !== x_of(2)) begin errors++; $display("FAIL mask_grant2: got %b x=%0d want 0100 x=%0d", aw_r, wr_r.wr_x, x_of(2)); end
    pulse_done(2);
    tick();
    checks++; if ({busy_r, aw_r} !== 5'b0_0000) begin errors++; $display("FAIL mask_end: got %b want 00000", {busy_r, aw_r}); end
  endtask

  task automatic test_watchdog();
    int n;
    do_reset();
    src_enable = '1; src_active = '1;
    pulse_frame();
    tick();
    pulse_done(0);
    tick();
    n = 0;
    while (aw_r === 4'b0010 && n < 20) begin n++; tick(); end
    checks++; if (n != 8) begin errors++; $display("FAIL wd_hold_cycles: got %0d want 8", n); end
    checks++; if ({tflag_r, tsrc_r} !== {1'b1, 4'd1}) begin errors++; $display("FAIL wd_flag_src: got %b/%0d want 1/1", tflag_r, tsrc_r); end
    tick();
    checks++; if (aw_r !== 4'b0100) begin errors++; $display("FAIL wd_next_grant: got %b want 0100", aw_r); end
  endtask

  task automatic test_overrun();
    do_reset();
    src_enable = '1; src_active = '1;
    pulse_frame();
    tick();
    pulse_done(0);
    tick();
    pulse_done(1);
    tick();
    checks++; if (aw_r !== 4'b0100 || aw_n !== 4'b0100) begin errors++; $display("FAIL ovr_pre: got %b/%b want 0100/0100", aw_r, aw_n); end
    pulse_frame();
    checks++; if ({ovr_r, aw_r, busy_r} !== {8'd1, 4'b0000, 1'b1}) begin errors++; $display("FAIL ovr_restart_scan: got %0d/%b/%b want 1/0000/1", ovr_r, aw_r, busy_r); end
    checks++; if ({ovr_n, aw_n} !== {8'd1, 4'b0100}) begin errors++; $display("FAIL ovr_norestart_hold: got %0d/%b want 1/0100", ovr_n, aw_n); end
    pulse_done(2);
    checks++; if (aw_r !== 4'b0001) begin errors++; $display("FAIL ovr_restart_grant0: got %b want 0001", aw_r); end
    tick();
    checks++; if (aw_n !== 4'b1000) begin errors++; $display("FAIL ovr_norestart_grant3: got %b want 1000", aw_n); end
    pulse_done(3);
    checks++; if ({busy_n, aw_n, ovr_n} !== {1'b0, 4'b0000, 8'd1}) begin errors++; $display("FAIL ovr_norestart_end: got %b/%b/%0d want 0/0000/1", busy_n, aw_n, ovr_n); end
  endtask

  task automatic test_saturation_and_collision();
    do_reset();
    src_enable = '1; src_active = '1;
    pulse_frame();
    tick();
    for (int k = 0; k < 300; k++) begin
      pulse_frame();
      tick();
      if (k == 99) begin
        checks++; if (ovr_r !== 8'd100) begin errors++; $display("FAIL sat_mid: got %0d want 100", ovr_r); end
      end
    end
    checks++; if (ovr_r !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d want 255", ovr_r); end
    do_reset();
    pulse_frame();
    tick();
    src_done = 4'b0001; frame = 1'b1;
    tick();
    src_done = '0; frame = 1'b0;
    checks++; if ({aw_r, ovr_r} !== {4'b0000, 8'd1}) begin errors++; $display("FAIL collide_scan: got %b/%0d want 0000/1", aw_r, ovr_r); end
    tick();
    checks++; if (aw_r !== 4'b0001) begin errors++; $display("FAIL collide_restart_wins: got %b want 0001", aw_r); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    src_enable = '1; src_active = '1;
    pulse_frame();
    tick();
    repeat (8) tick();
    tick();
    checks++; if ({aw_r, tflag_r, tsrc_r} !== {4'b0010, 1'b1, 4'd0}) begin errors++; $display("FAIL rst_pre_timeout: got %b/%b/%0d want 0010/1/0", aw_r, tflag_r, tsrc_r); end
    pulse_frame();
    tick();
    checks++; if ({aw_r, ovr_r, wr_r.wr_active} !== {4'b0001, 8'd1, 1'b1}) begin errors++; $display("FAIL rst_pre_grant: got %b/%0d/%b want 0001/1/1", aw_r, ovr_r, wr_r.wr_active); end
    reset = 1'b1;
    tick();
    checks++; if ({aw_r, wr_r.wr_active, wr_r.wr_color, wr_r.wr_x, wr_r.wr_y, wr_r.wr_transparent, wr_r.wr_source_sel} !== '0) begin
      errors++; $display("FAIL rst_mid_bus: got %b/%b/%h want all 0", aw_r, wr_r.wr_active, {wr_r.wr_color, wr_r.wr_x, wr_r.wr_y}); end
    checks++; if ({busy_r, ovr_r, tflag_r, tsrc_r} !== '0) begin errors++; $display("FAIL rst_mid_status: got %b/%0d/%b/%0d want 0/0/0/0", busy_r, ovr_r, tflag_r, tsrc_r); end
    reset = 1'b0;
    pulse_frame();
    tick();
    checks++; if ({aw_r, ovr_r} !== {4'b0001, 8'd0}) begin errors++; $display("FAIL rst_new_pass: got %b/%0d want 0001/0", aw_r, ovr_r); end
  endtask

  initial begin
    reset = 1'b1; frame = 1'b0; src_done = '0; src_enable = '0; src_active = '0;
    src_transparent = '0; src_color = '0; src_x = '0; src_y = '0;
    for (int i = 0; i < NS; i++) begin
      src_color[i*CD +: CD] = col_of(i);
      src_x[i*XW +: XW]     = x_of(i);
      src_y[i*YW +: YW]     = y_of(i);
      src_transparent[i]    = tr_of(i);
    end
    test_reset();
    test_painter_order();
    test_enable_mask();
    test_watchdog();
    test_overrun();
    test_saturation_and_collision();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_write_sequencer.md
Name: frame_write_sequencer

Overview:
- Parametrised per-frame write sequencer between N drawing sources and the frame manager's single write port.
- Generalises the fixed layered scheme (background, starfield, calibration overlay) to NUM_SOURCES layers.
- Adds a per-source enable mask, a watchdog timeout per layer, and frame-overrun handling.
- Each frame, grants the write port to enabled sources in ascending index order (painter's order); the last source drawn is on top.

Parameters:
- NUM_SOURCES, 4, number of drawing sources (2..16).
- SOURCE_SEL_ADDRW, 4, width of wr_source_sel; must satisfy 2^SOURCE_SEL_ADDRW >= NUM_SOURCES.
- COLOR_DEPTH, 9, bits per pixel colour word.
- DRAW_WIDTH_ADDRW, 10, x address width.
- DRAW_HEIGHT_ADDRW, 9, y address width.
- TIMEOUT_CYCLES, 0, maximum cycles in one grant before a forced advance; 0 disables the watchdog.
- OVERRUN_RESTART, 1, frame pulse mid-pass: 1 restarts the pass at source 0; 0 ignores the pulse and finishes the current pass.

Ports:
- clk  in  1  system clock (25 MHz draw clock).
- reset  in  1  synchronous, active-high reset.
- frame  in  1  one-cycle pulse at start of frame.
- src_enable  in  NUM_SOURCES  per-source enable mask, sampled in SCAN.
- src_active  in  NUM_SOURCES  source is presenting a write this cycle.
- src_done  in  NUM_SOURCES  one-cycle pulse: source finished its layer.
- src_color  in  NUM_SOURCES*COLOR_DEPTH  packed colour buses; source i at [i*COLOR_DEPTH +: COLOR_DEPTH].
- src_transparent  in  NUM_SOURCES  per-source transparent flag.
- src_x  in  NUM_SOURCES*DRAW_WIDTH_ADDRW  packed x addresses.
- src_y  in  NUM_SOURCES*DRAW_HEIGHT_ADDRW  packed y addresses.
- src_awaited  out  NUM_SOURCES  one-hot grant; at most one bit set.
- wr_active  out  1  write strobe to the frame manager.
- wr_transparent  out  1  muxed transparent flag.
- wr_color  out  COLOR_DEPTH  muxed colour.
- wr_x  out  DRAW_WIDTH_ADDRW  muxed x address.
- wr_y  out  DRAW_HEIGHT_ADDRW  muxed y address.
- wr_source_sel  out  SOURCE_SEL_ADDRW  index of the granted source.
- pass_busy  out  1  high in SCAN or GRANT.
- overrun_count  out  8  saturating count of frame pulses arriving mid-pass.
- timeout_flag  out  1  sticky; set on any watchdog expiry.
- timeout_src  out  SOURCE_SEL_ADDRW  index of the most recent timed-out source.

Behaviour:
- States: WAIT, SCAN, GRANT. Reset -> WAIT, idx=0.
- Reset values: all outputs 0, including counters and sticky flags.
- WAIT: frame=1 -> SCAN with idx=0.
- SCAN: one index per cycle.
  - src_enable[idx]=1 -> GRANT, watchdog cleared.
  - Otherwise, if idx=NUM_SOURCES-1 -> WAIT; else idx+1.
- GRANT:
  - src_awaited[idx]=1 and wr_source_sel=idx, both registered.
  - Write bus is combinationally muxed from source idx; wr_active = src_active[idx].
  - src_done[idx] or watchdog expiry -> advance: idx=NUM_SOURCES-1 -> WAIT; else idx+1 and SCAN.
  - src_done from non-granted sources is ignored.
- Outside GRANT: src_awaited=0, wr_active=0. The write bus may carry don't-care data but wr_active must be 0.
- Latency: frame sampled at cycle t -> SCAN at t+1 -> src_awaited[0]=1 at t+2 if source 0 is enabled. Each skipped source costs one cycle.
- Watchdog:
  - Counter increments every GRANT cycle.
  - Reaching TIMEOUT_CYCLES-1 without src_done forces an advance, sets timeout_flag, and loads timeout_src=idx.
  - src_done on the expiry cycle counts as normal completion; no flag is set.
- Overrun (frame=1 while in SCAN or GRANT):
  - overrun_count increments, saturating at 255.
  - OVERRUN_RESTART=1: next state SCAN with idx=0, overriding any simultaneous src_done or timeout advance.
  - OVERRUN_RESTART=0: the pulse is ignored; the pass continues; the next pass needs a new frame pulse after reaching WAIT.
- frame in WAIT never counts as an overrun.
- All sources disabled: the pass is SCAN x NUM_SOURCES cycles, then WAIT; no grants.
- src_enable changes mid-pass affect only sources not yet scanned.
- reset mid-pass: returns to WAIT next cycle, grant dropped immediately, counters and flags cleared.

Test Plan:
1. NUM_SOURCES=4, all enabled, src_done pulsed 5 cycles after each grant; frame at cycle 10 -> src_awaited 0001 from 12; then 0010, 0100, 1000 in order; WAIT after the src_done of source 3; wr_x/wr_y/wr_color track the granted source only.
2. src_enable=0101 -> grants only to sources 0 and 2, each skipped source adds 1 SCAN cycle; src_active[1]=1 never produces wr_active.
3. TIMEOUT_CYCLES=8, source 1 never pulses done -> grant held exactly 8 cycles, then source 2 granted; timeout_flag=1, timeout_src=1.
4. OVERRUN_RESTART=1, frame pulse while source 2 is granted -> overrun_count=1, src_awaited returns to 0001 two cycles later. Repeat with OVERRUN_RESTART=0 -> pass completes, overrun_count=1, no restart.
5. 300 mid-pass frame pulses -> overrun_count saturates at 255. src_done and frame on the same cycle with OVERRUN_RESTART=1 -> restart wins.
6. reset asserted while in GRANT -> next cycle all outputs 0, state WAIT; a subsequent frame pulse starts a normal pass.
